// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial WIDTH-bit subtractor D = A - B - Bin, LSB first
// Optional signed-overflow flag enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [CW-1:0]    r_cnt;
  logic             r_br;
  logic [WIDTH-1:0] r_d;
  logic             r_bout;

  logic             w_d;
  logic             w_br_next;
  logic             w_last;
  logic [WIDTH-1:0] w_res_next;

  // One full-subtractor cell working on the current LSBs and the borrow flop
  assign w_d        = r_a[0] ^ r_b[0] ^ r_br;
  assign w_br_next  = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
  assign w_res_next = {w_d, r_res[WIDTH-1:1]};
  assign w_last     = (r_cnt == CW'(WIDTH - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_br    <= 1'b0;
      r_d     <= '0;
      r_bout  <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a   <= A;
            r_b   <= B;
            r_br  <= Bin;
            r_cnt <= '0;
          end
        end
        S_RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_br  <= w_br_next;
          r_res <= w_res_next;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_d    <= w_res_next;
            r_bout <= w_br_next;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  // Operand MSBs are kept aside because the shift registers lose them during RUN
  logic r_a_msb;
  logic r_b_msb;
  logic r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_a_msb <= A[WIDTH-1];
        r_b_msb <= B[WIDTH-1];
      end
      if (r_state == S_RUN && w_last) begin
        r_ovf <= (r_a_msb != r_b_msb) && (w_res_next[WIDTH-1] != r_a_msb);
      end
    end
  end

  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign D    = r_d;
  assign Bout = r_bout;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed vector bench for serial_subtractor (WIDTH=4)
// Expected ovf follows SERIAL_SUB_OVF_EN when the macro is defined for the build.
module tb_serial_subtractor;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] D;
  logic             Bout;
  logic             ovf;

  int n_cmp;
  int n_bad;
  logic [WIDTH-1:0] prev_d;
  logic             prev_bout;
  logic             prev_ovf;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             ovf_en;
  } vec_t;

  vec_t vecs [8];

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .busy  (busy),
    .done  (done),
    .D     (D),
    .Bout  (Bout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic exp_ovf(input logic ovf_en);
`ifdef SERIAL_SUB_OVF_EN
    return ovf_en;
`else
    return 1'b0 & ovf_en;
`endif
  endfunction

  task automatic run_op(input vec_t v);
    int lat;
    lat = 0;
    @(negedge clk);
    A = v.a; B = v.b; Bin = v.bin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = ~v.a; B = ~v.b; Bin = ~v.bin;
    while (!done && lat < 20) begin
      check("busy_run", busy, 1);
      check("d_hold", D, prev_d);
      check("bout_hold", Bout, prev_bout);
      @(negedge clk);
      lat++;
    end
    check("latency", lat, WIDTH);
    check("busy_done", busy, 0);
    check("d", D, v.d);
    check("bout", Bout, v.bout);
    check("ovf", ovf, exp_ovf(v.ovf_en));
    @(negedge clk);
    check("done_pulse", done, 0);
    prev_d = v.d; prev_bout = v.bout; prev_ovf = exp_ovf(v.ovf_en);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    prev_d = '0; prev_bout = 1'b0; prev_ovf = 1'b0;
    //            a        b        bin   d        bout  ovf
    vecs[0] = '{4'b0101, 4'b0011, 1'b0, 4'b0010, 1'b0, 1'b0};
    vecs[1] = '{4'b0011, 4'b0101, 1'b0, 4'b1110, 1'b1, 1'b0};
    vecs[2] = '{4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b1, 1'b0};
    vecs[3] = '{4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0};
    vecs[4] = '{4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b1};
    vecs[5] = '{4'b0111, 4'b1000, 1'b0, 4'b1111, 1'b1, 1'b1};
    vecs[6] = '{4'b1010, 4'b0101, 1'b0, 4'b0101, 1'b0, 1'b1};
    vecs[7] = '{4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, 1'b0};

    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_d", D, 0);
    check("rst_bout", Bout, 0);
    check("rst_ovf", ovf, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_op(vecs[i]);

    // Held start: a new operation every WIDTH+2 cycles, same result each time
    begin
      int pulses;
      int last_t;
      logic prev_done;
      pulses = 0; last_t = -1; prev_done = 1'b0;
      @(negedge clk);
      A = 4'b1010; B = 4'b0101; Bin = 1'b0; start = 1'b1;
      for (int t = 0; t < 20; t++) begin
        @(negedge clk);
        if (done) begin
          check("held_d", D, 4'b0101);
          check("held_bout", Bout, 0);
          check("held_no_double", prev_done, 0);
          if (last_t >= 0) check("held_period", t - last_t, WIDTH + 2);
          last_t = t;
          pulses++;
        end
        prev_done = done;
      end
      start = 1'b0;
      check("held_pulses", pulses, 3);
      repeat (WIDTH + 2) @(negedge clk);
      check("held_idle", busy, 0);
      prev_d = 4'b0101; prev_bout = 1'b0; prev_ovf = exp_ovf(1'b1);
    end

    // Reset two cycles into RUN clears outputs without waiting for a clock edge
    @(negedge clk);
    A = 4'b0011; B = 4'b0101; Bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre_rst_busy", busy, 1);
    check("pre_rst_d", D, 4'b0101);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_d", D, 0);
    check("mid_rst_bout", Bout, 0);
    check("mid_rst_ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    prev_d = '0; prev_bout = 1'b0; prev_ovf = 1'b0;
    run_op(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
